// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator CPU: word/address widths, op-codes,
// IR field positions and the controller state encoding.
package cpu_pkg;

    localparam int CPU_WORD_W = 8;
    localparam int CPU_ADDR_W = 6;
    localparam int CPU_OPC_W  = 2;

    // Instruction register fields: op-code in the top bits, operand below
    localparam int IR_OPC_MSB = CPU_WORD_W - 1;
    localparam int IR_OPD_MSB = CPU_ADDR_W - 1;
    localparam int IR_OPD_LSB = 0;

    localparam logic [CPU_OPC_W-1:0] OP_ADDI  = 2'b00;
    localparam logic [CPU_OPC_W-1:0] OP_LOAD  = 2'b01;
    localparam logic [CPU_OPC_W-1:0] OP_STORE = 2'b10;
    localparam logic [CPU_OPC_W-1:0] OP_JMP   = 2'b11;

    // Four-state controller sequence that drives this datapath
    typedef enum logic [1:0] {
        ST_FETCH  = 2'b00,
        ST_DECODE = 2'b01,
        ST_EXEC   = 2'b10,
        ST_WRBACK = 2'b11
    } ctrl_state_t;

endpackage

// File: rtl/pc_counter.sv
// Program counter: clear beats load beats increment; increment wraps silently.
module pc_counter
    import cpu_pkg::*;
#(
    parameter int ADDR_W = CPU_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              load,
    input  logic              inc,
    input  logic [ADDR_W-1:0] load_val,
    output logic [ADDR_W-1:0] pc
);

    // Prioritised next-PC update, cleared asynchronously
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc <= '0;
        end else if (clr) begin
            pc <= '0;
        end else if (load) begin
            pc <= load_val;
        end else if (inc) begin
            pc <= pc + ADDR_W'(1);
        end
    end

endmodule

// File: rtl/accumulator_datapath.sv
// Accumulator CPU datapath: PC, IR, AC, carry/zero flags, adder and the
// memory bus mux, steered cycle by cycle by the controller strobes.
module accumulator_datapath
    import cpu_pkg::*;
#(
    parameter int WORD_W = CPU_WORD_W,
    parameter int ADDR_W = CPU_ADDR_W,
    parameter int OPC_W  = CPU_OPC_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_mem,
    input  logic              wr_mem,
    input  logic              ir_on_adr,
    input  logic              pc_on_adr,
    input  logic              ld_ir,
    input  logic              ld_ac,
    input  logic              ld_pc,
    input  logic              inc_pc,
    input  logic              clr_pc,
    input  logic              pass_add,
    input  logic [WORD_W-1:0] mem_rdata,
    output logic [OPC_W-1:0]  op_code,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [WORD_W-1:0] ac,
    output logic [ADDR_W-1:0] pc,
    output logic              carry,
    output logic              zero,
    output logic              bus_err
);

    logic [WORD_W-1:0] ir;
    logic [WORD_W-1:0] operand;
    logic [WORD_W:0]   sum;
    logic [WORD_W-1:0] result;
    logic              cout;
    logic              proto_err;

    assign operand   = {{(WORD_W-ADDR_W){1'b0}}, ir[ADDR_W-1:0]};
    assign op_code   = ir[WORD_W-1 -: OPC_W];
    assign mem_wdata = ac;
    // Strobes drop immediately while reset is held, even mid-instruction
    assign mem_rd    = rd_mem & reset;
    assign mem_wr    = wr_mem & reset;

    pc_counter #(
        .ADDR_W (ADDR_W)
    ) u_pc (
        .clk      (clk),
        .reset    (reset),
        .clr      (clr_pc),
        .load     (ld_pc),
        .inc      (inc_pc),
        .load_val (ir[ADDR_W-1:0]),
        .pc       (pc)
    );

    // Address mux: PC wins over the IR operand; idle bus shows zero
    always_comb begin
        mem_addr = '0;
        if (!reset) begin
            mem_addr = '0;
        end else if (pc_on_adr) begin
            mem_addr = pc;
        end else if (ir_on_adr) begin
            mem_addr = ir[ADDR_W-1:0];
        end
    end

    // ALU: add the zero-extended operand to AC, or pass memory data through
    always_comb begin
        sum    = {1'b0, ac} + {1'b0, operand};
        result = mem_rdata;
        cout   = 1'b0;
        if (pass_add) begin
            result = sum[WORD_W-1:0];
            cout   = sum[WORD_W];
        end
    end

    // Strobe combinations the controller should never produce
    always_comb begin
        proto_err = (rd_mem & wr_mem)
                  | (pc_on_adr & ir_on_adr)
                  | ((rd_mem | wr_mem) & ~pc_on_adr & ~ir_on_adr)
                  | (clr_pc & ld_pc) | (clr_pc & inc_pc) | (ld_pc & inc_pc);
    end

    // Instruction register load from the memory read bus
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ir <= '0;
        end else if (ld_ir) begin
            ir <= mem_rdata;
        end
    end

    // Accumulator and flags; carry only changes on an add
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ac    <= '0;
            zero  <= 1'b0;
            carry <= 1'b0;
        end else if (ld_ac) begin
            ac   <= result;
            zero <= (result == '0);
            if (pass_add) begin
                carry <= cout;
            end
        end
    end

    // Sticky protocol-violation flag, cleared only by reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus_err <= 1'b0;
        end else if (proto_err) begin
            bus_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_accumulator_datapath.sv
// Directed bench for the accumulator datapath with hand-computed expectations.
module tb_accumulator_datapath;

    logic       clk = 1'b0;
    logic       reset;
    logic       rd_mem, wr_mem, ir_on_adr, pc_on_adr;
    logic       ld_ir, ld_ac, ld_pc, inc_pc, clr_pc, pass_add;
    logic [7:0] mem_rdata;
    logic [1:0] op_code;
    logic [5:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       mem_rd, mem_wr;
    logic [7:0] ac;
    logic [5:0] pc;
    logic       carry, zero, bus_err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    accumulator_datapath dut (
        .clk       (clk),
        .reset     (reset),
        .rd_mem    (rd_mem),
        .wr_mem    (wr_mem),
        .ir_on_adr (ir_on_adr),
        .pc_on_adr (pc_on_adr),
        .ld_ir     (ld_ir),
        .ld_ac     (ld_ac),
        .ld_pc     (ld_pc),
        .inc_pc    (inc_pc),
        .clr_pc    (clr_pc),
        .pass_add  (pass_add),
        .mem_rdata (mem_rdata),
        .op_code   (op_code),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .ac        (ac),
        .pc        (pc),
        .carry     (carry),
        .zero      (zero),
        .bus_err   (bus_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        rd_mem = 0; wr_mem = 0; ir_on_adr = 0; pc_on_adr = 0;
        ld_ir = 0; ld_ac = 0; ld_pc = 0; inc_pc = 0; clr_pc = 0; pass_add = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Load IR directly from the read bus (no memory strobe needed)
    task automatic load_ir(input logic [7:0] v);
        idle(); ld_ir = 1; mem_rdata = v;
        tick();
        idle();
    endtask

    // LOAD-style transfer: AC <= mem_rdata through the pass path
    task automatic load_ac(input logic [7:0] v);
        idle(); ir_on_adr = 1; rd_mem = 1; ld_ac = 1; mem_rdata = v;
        tick();
        idle();
    endtask

    initial begin
        logic [9:0] r;
        reset = 0;
        mem_rdata = 8'hA5;
        idle();

        // Reset held with random strobes
        for (int i = 0; i < 4; i++) begin
            r = 10'($urandom);
            {rd_mem, wr_mem, ir_on_adr, pc_on_adr, ld_ir, ld_ac, ld_pc, inc_pc, clr_pc, pass_add} = r;
            tick();
        end
        rd_mem = 1; wr_mem = 1; pc_on_adr = 1; #1;
        chk("rst_pc", 32'(pc), 0);
        chk("rst_ac", 32'(ac), 0);
        chk("rst_op", 32'(op_code), 0);
        chk("rst_mem_wr", 32'(mem_wr), 0);
        chk("rst_mem_rd", 32'(mem_rd), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_bus_err", 32'(bus_err), 0);
        chk("rst_flags", 32'({carry, zero}), 0);

        // Release between edges, then clear PC
        idle(); #1;
        reset = 1;
        clr_pc = 1;
        tick();
        idle();
        chk("clr_pc", 32'(pc), 0);
        chk("clr_bus_err", 32'(bus_err), 0);

        // Put PC at 5 by jumping to IR operand 5
        load_ir(8'h05);
        ld_pc = 1; tick(); idle();
        chk("jmp5_pc", 32'(pc), 5);

        // Fetch of 8'h47 at PC=5
        pc_on_adr = 1; rd_mem = 1; ld_ir = 1; inc_pc = 1; mem_rdata = 8'h47; #1;
        chk("fetch_addr", 32'(mem_addr), 5);
        chk("fetch_rd", 32'(mem_rd), 1);
        chk("fetch_op_before", 32'(op_code), 0);
        tick(); idle();
        chk("fetch_pc", 32'(pc), 6);
        chk("fetch_op", 32'(op_code), 1);

        // ADDI overflow to zero: FC + 04
        load_ac(8'hFC);
        chk("ldfc_ac", 32'(ac), 32'hFC);
        chk("ldfc_zero", 32'(zero), 0);
        load_ir(8'h04);
        pass_add = 1; ld_ac = 1; mem_rdata = 8'h77; tick(); idle();
        chk("addi_ac", 32'(ac), 0);
        chk("addi_carry", 32'(carry), 1);
        chk("addi_zero", 32'(zero), 1);
        load_ac(8'h10);
        chk("load_ac", 32'(ac), 32'h10);
        chk("load_zero", 32'(zero), 0);
        chk("load_carry_hold", 32'(carry), 1);

        // ADDI without carry clears carry: 10 + 04
        pass_add = 1; ld_ac = 1; tick(); idle();
        chk("addi2_ac", 32'(ac), 32'h14);
        chk("addi2_carry", 32'(carry), 0);

        // STORE: IR=9A, AC=3C
        load_ir(8'h9A);
        load_ac(8'h3C);
        ir_on_adr = 1; wr_mem = 1; #1;
        chk("st_addr", 32'(mem_addr), 32'h1A);
        chk("st_wdata", 32'(mem_wdata), 32'h3C);
        chk("st_wr", 32'(mem_wr), 1);
        chk("st_op", 32'(op_code), 2);
        tick(); idle(); #1;
        chk("st_wr_drop", 32'(mem_wr), 0);
        chk("st_idle_addr", 32'(mem_addr), 0);
        chk("st_bus_err", 32'(bus_err), 0);

        // Address mux priority with both selects (also flags a violation)
        pc_on_adr = 1; ir_on_adr = 1; #1;
        chk("mux_pri", 32'(mem_addr), 6);
        idle();

        // JMP to 0, then wrap 63 -> 0
        load_ir(8'hC0);
        ld_pc = 1; tick(); idle();
        chk("jmp0_pc", 32'(pc), 0);
        load_ir(8'h3F);
        ld_pc = 1; tick(); idle();
        chk("jmp63_pc", 32'(pc), 63);
        inc_pc = 1; tick(); idle();
        chk("wrap_pc", 32'(pc), 0);
        inc_pc = 1; tick(); idle();
        chk("inc_pc", 32'(pc), 1);
        chk("pre_err", 32'(bus_err), 0);
        clr_pc = 1; ld_pc = 1; tick(); idle();
        chk("clr_ld_pc", 32'(pc), 0);
        chk("clr_ld_err", 32'(bus_err), 1);
        tick();
        chk("err_sticky", 32'(bus_err), 1);

        // Async reset in the middle of a LOAD
        inc_pc = 1; tick(); idle();
        load_ac(8'h55);
        chk("pre_rst_ac", 32'(ac), 32'h55);
        ir_on_adr = 1; rd_mem = 1; ld_ac = 1; mem_rdata = 8'h66;
        #2;
        reset = 0;
        #1;
        chk("arst_ac", 32'(ac), 0);
        chk("arst_pc", 32'(pc), 0);
        chk("arst_err", 32'(bus_err), 0);
        chk("arst_rd", 32'(mem_rd), 0);
        chk("arst_op", 32'(op_code), 0);
        idle();
        #2;
        reset = 1;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/accumulator_datapath.md
Name: accumulator_datapath

Overview:
- Datapath stage directly downstream of the 4-state CPU controller: consumes its ten control strobes and returns the current op-code.
- Holds PC, IR, AC, carry/zero flags and the adder, and drives the memory address/data bus.
- Memory is external with a combinational (same-cycle) read and a write-on-clock-edge.

Parameters:
WORD_W, 8, data/instruction word width
ADDR_W, 6, address width; must equal WORD_W-2
OPC_W, 2, op-code width (IR[WORD_W-1 -: OPC_W])

Ports:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  asynchronous, active-low; clears all registers
rd_mem  in  1  controller: memory read this cycle
wr_mem  in  1  controller: memory write this cycle
ir_on_adr  in  1  controller: address bus <- IR operand
pc_on_adr  in  1  controller: address bus <- PC
ld_ir  in  1  controller: IR <- mem_rdata
ld_ac  in  1  controller: AC <- ALU result
ld_pc  in  1  controller: PC <- IR operand (jump)
inc_pc  in  1  controller: PC <- PC+1
clr_pc  in  1  controller: PC <- 0
pass_add  in  1  ALU select: 1 = AC+operand, 0 = pass mem_rdata
op_code  out  OPC_W  IR[7:6], to controller
mem_addr  out  ADDR_W  memory address
mem_wdata  out  WORD_W  write data (AC)
mem_rd  out  1  memory read strobe
mem_wr  out  1  memory write strobe
ac  out  WORD_W  accumulator value (debug/observe)
pc  out  ADDR_W  program counter value
carry  out  1  carry out of last add
zero  out  1  AC==0 after last AC load
bus_err  out  1  sticky protocol-violation flag

Behaviour:
- Reset (reset=0, async): PC=0, IR=0, AC=0, carry=0, zero=0, bus_err=0; op_code=0, mem_addr=0, mem_wr=0, mem_rd=0. Leaving reset takes effect at the first rising edge with reset=1.
- Address mux (combinational): pc_on_adr -> PC; else ir_on_adr -> IR[ADDR_W-1:0]; else 0. pc_on_adr wins when both are high.
- Memory strobes and data:
  - mem_rd = rd_mem; mem_wr = wr_mem; mem_wdata = AC at all times.
  - Zero-latency pass-through; the write lands at the edge ending the cycle.
- IR: on edge with ld_ir, IR <= mem_rdata. op_code = IR[7:6] registered, so a new op-code is visible the cycle after fetch.
- PC priority at each edge: clr_pc > ld_pc > inc_pc > hold.
  - ld_pc loads IR[5:0].
  - inc_pc wraps 2^ADDR_W-1 -> 0 with no flag.
  - In a fetch, mem_addr shows pre-increment PC.
- ALU:
  - pass_add=1: {cout,sum} = AC + zero-extended IR[5:0], width WORD_W+1.
  - pass_add=0: result = mem_rdata, cout=0.
- AC/flags: on edge with ld_ac:
  - AC <= result; zero <= (result[WORD_W-1:0]==0).
  - carry <= cout if pass_add, else carry holds.
  - Flags hold when ld_ac=0.
- bus_err is set (sticky until reset) at any edge where:
  - rd_mem & wr_mem, or
  - pc_on_adr & ir_on_adr, or
  - (rd_mem|wr_mem) with neither address select, or
  - more than one of clr_pc/ld_pc/inc_pc.
  Priority resolution above still applies; the datapath never blocks.
- Reset mid-instruction: all registers clear immediately and strobes drop in the same cycle. No partial write is guaranteed unless the memory samples mem_wr before reset asserts.
- Instruction set as sequenced by the controller:
  - 00 = ADDI: AC += operand.
  - 01 = LOAD: AC <= M[op].
  - 10 = STORE: M[op] <= AC.
  - 11 = JMP: PC <= op.

Decomposition:
- Shared package cpu_pkg: WORD_W/ADDR_W/OPC_W constants, op-code localparams (OP_ADDI=2'b00, OP_LOAD=2'b01, OP_STORE=2'b10, OP_JMP=2'b11), and IR field slice positions. Controller state codes belong in the same package.
- One natural sub-module: pc_counter (clear/load/increment with priority and wrap).
- ALU, AC, IR and the bus mux stay inline.

Test Plan:
- Reset check: hold reset=0 with random strobes -> pc=0, ac=0, op_code=0, mem_wr=0, bus_err=0. Release, then one edge with clr_pc -> pc stays 0.
- Fetch: PC=5, mem_rdata=8'h47, assert pc_on_adr/rd_mem/ld_ir/inc_pc -> mem_addr=5 in that cycle. After the edge, pc=6 and op_code=2'b01.
- ADDI carry/zero: AC=8'hFC, IR=8'h04, pass_add+ld_ac -> ac=8'h00, carry=1, zero=1. Then LOAD of 8'h10 -> ac=8'h10, zero=0, carry stays 1.
- STORE/LOAD: IR=8'h9A, AC=8'h3C, ir_on_adr+wr_mem -> mem_addr=6'h1A, mem_wdata=8'h3C, mem_wr=1 for exactly one cycle.
- JMP/wrap: IR=8'hC0 with ld_pc -> pc=0. PC=63 with inc_pc -> pc=0. clr_pc+ld_pc together -> pc=0 and bus_err=1.
- Async reset mid-execute: drop reset between edges during LOAD -> ac, pc and bus_err clear immediately without waiting for clk.
